rr_encoder_arbiter: RTL and testbench

Four-requester round-robin arbiter that shares the team's 4-to-2 encoder resource. It holds a one-hot grant and its 2-bit encoded index until the owner releases, the owner drops its request, or a hold timeout expires. Priority rotates after every grant. It sits between requesting agents d0..d3 and the downstream consumer of the encoded b1:b0 index.

---
 rtl/rr_encoder_arbiter.sv | 140 ++++++++++++++
 tb/tb_rr_encoder_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_encoder_arbiter.sv
// ----------------------------------------------------------------------------
// rr_encoder_arbiter
//   Four-requester round-robin arbiter that also drives the shared 4-to-2
//   encoder output. A grant is held until the owner releases it, the owner
//   drops its request, or the grant has been valid for MAX_HOLD cycles.
//   After every grant the priority pointer moves to the index just past the
//   owner. Consecutive grants are always separated by at least one idle cycle.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   req[3:0]     request lines, req[i] belongs to requester i
//   release_i    owner finished; only looked at while grant_valid=1
//   grant[3:0]   one-hot grant, zero when idle
//   grant_idx    encoded owner index {b1,b0}, zero when idle
//   grant_valid  a grant is active
//   timeout      one-cycle pulse when a grant was revoked by the hold limit
//   ptr          current highest-priority index (debug)
// ----------------------------------------------------------------------------
module rr_encoder_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       release_i,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout,
    output logic [1:0] ptr
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] grant_idx_q, grant_idx_d;
    logic       grant_valid_q, grant_valid_d;
    logic       timeout_q, timeout_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;

    logic [1:0] sel;
    logic [1:0] scan_idx;
    logic       found;
    logic       ev_rel, ev_drop, ev_limit;

    always_comb begin
        // Round-robin scan: ptr first, then ptr+1.. wrapping mod 4.
        sel      = ptr_q;
        scan_idx = ptr_q;
        found    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                sel   = scan_idx;
            end
        end

        ev_rel   = release_i;
        ev_drop  = !req[grant_idx_q];
        ev_limit = (hold_cnt_q == 8'(MAX_HOLD));

        state_d       = state_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = GRANT;
                    grant_d       = 4'b0001 << sel;
                    grant_idx_d   = sel;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = 8'd1;
                end
            end
            GRANT: begin
                if (ev_rel || ev_drop || ev_limit) begin
                    state_d       = IDLE;
                    grant_d       = 4'b0000;
                    grant_idx_d   = 2'd0;
                    grant_valid_d = 1'b0;
                    hold_cnt_d    = 8'd0;
                    ptr_d         = grant_idx_q + 2'd1;
                    // Only flag a timeout when the hold limit alone ended it.
                    timeout_d     = ev_limit && !ev_rel && !ev_drop;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= 4'b0000;
            grant_idx_q   <= 2'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            ptr_q         <= 2'd0;
            hold_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;
    assign ptr         = ptr_q;

    // Output invariants: grant is zero/one-hot, valid tracks grant,
    // and the index is the encoding of the grant (zero when idle).
    a_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(grant_q));
    a_valid : assert property (@(posedge clk) disable iff (rst)
        grant_valid_q == (grant_q != 4'b0000));
    a_encode : assert property (@(posedge clk) disable iff (rst)
        grant_valid_q ? (grant_q == (4'b0001 << grant_idx_q)) : (grant_idx_q == 2'd0));

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_encoder_arbiter
//   Directed bench for rr_encoder_arbiter (MAX_HOLD=8). Each task drives one
//   scenario and compares the packed output word
//   {grant, grant_idx, grant_valid, timeout, ptr} against hand-computed values.
// ----------------------------------------------------------------------------
module tb_rr_encoder_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       release_i;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;
    logic [1:0] ptr;

    int checks = 0;
    int errors = 0;

    logic [9:0] obs;
    assign obs = {grant, grant_idx, grant_valid, timeout, ptr};

    rr_encoder_arbiter #(.MAX_HOLD(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .release_i  (release_i),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout),
        .ptr        (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs changed after this are seen at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; release_i = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; release_i = 1'b1;
        step();
        step();
        checks++;
        if (obs !== 10'b0000_00_0_0_00) begin
            errors++;
            $display("FAIL reset got %b want %b", obs, 10'b0000_00_0_0_00);
        end
        rst = 1'b0; req = 4'b0000; release_i = 1'b0;
    endtask

    task automatic test_idle_release();
        do_reset();
        release_i = 1'b1;
        step();
        step();
        checks++;
        if (obs !== 10'b0000_00_0_0_00) begin
            errors++;
            $display("FAIL idle_release got %b want %b", obs, 10'b0000_00_0_0_00);
        end
        release_i = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        req = 4'b0001;
        step();
        checks++;
        if (obs !== 10'b0001_00_1_0_00) begin
            errors++;
            $display("FAIL basic_grant got %b want %b", obs, 10'b0001_00_1_0_00);
        end
        release_i = 1'b1;
        step();
        checks++;
        if (obs !== 10'b0000_00_0_0_01) begin
            errors++;
            $display("FAIL basic_release got %b want %b", obs, 10'b0000_00_0_0_01);
        end
        release_i = 1'b0; req = 4'b0000;
        step();
        checks++;
        if (obs !== 10'b0000_00_0_0_01) begin
            errors++;
            $display("FAIL basic_idle got %b want %b", obs, 10'b0000_00_0_0_01);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] exp_i   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [1:0] exp_pb  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [1:0] exp_pa  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if (obs !== {exp_g[n], exp_i[n], 1'b1, 1'b0, exp_pb[n]}) begin
                errors++;
                $display("FAIL rot_grant%0d got %b want %b", n, obs,
                         {exp_g[n], exp_i[n], 1'b1, 1'b0, exp_pb[n]});
            end
            step();
            release_i = 1'b1;
            step();
            release_i = 1'b0;
            checks++;
            if (obs !== {4'b0000, 2'd0, 1'b0, 1'b0, exp_pa[n]}) begin
                errors++;
                $display("FAIL rot_idle%0d got %b want %b", n, obs,
                         {4'b0000, 2'd0, 1'b0, 1'b0, exp_pa[n]});
            end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b0100;
        step();
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        checks++;
        if (obs !== 10'b0000_00_0_0_11) begin
            errors++;
            $display("FAIL wrap_ptr3 got %b want %b", obs, 10'b0000_00_0_0_11);
        end
        req = 4'b0101;
        step();
        checks++;
        if (obs !== 10'b0001_00_1_0_11) begin
            errors++;
            $display("FAIL wrap_grant got %b want %b", obs, 10'b0001_00_1_0_11);
        end
        release_i = 1'b1;
        step();
        release_i = 1'b0; req = 4'b0000;
        checks++;
        if (obs !== 10'b0000_00_0_0_01) begin
            errors++;
            $display("FAIL wrap_ptr1 got %b want %b", obs, 10'b0000_00_0_0_01);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0010;
        for (int c = 1; c <= 8; c++) begin
            step();
            checks++;
            if (obs !== 10'b0010_01_1_0_00) begin
                errors++;
                $display("FAIL hold_cycle%0d got %b want %b", c, obs, 10'b0010_01_1_0_00);
            end
        end
        step();
        checks++;
        if (obs !== 10'b0000_00_0_1_10) begin
            errors++;
            $display("FAIL timeout_pulse got %b want %b", obs, 10'b0000_00_0_1_10);
        end
        step();
        checks++;
        if (obs !== 10'b0010_01_1_0_10) begin
            errors++;
            $display("FAIL timeout_regrant got %b want %b", obs, 10'b0010_01_1_0_10);
        end
        req = 4'b0000;
        step();
        checks++;
        if (obs !== 10'b0000_00_0_0_10) begin
            errors++;
            $display("FAIL timeout_drop got %b want %b", obs, 10'b0000_00_0_0_10);
        end
    endtask

    task automatic test_drop();
        do_reset();
        req = 4'b1000;
        step();
        step();
        step();
        checks++;
        if (obs !== 10'b1000_11_1_0_00) begin
            errors++;
            $display("FAIL drop_hold got %b want %b", obs, 10'b1000_11_1_0_00);
        end
        req = 4'b0000;
        step();
        checks++;
        if (obs !== 10'b0000_00_0_0_00) begin
            errors++;
            $display("FAIL drop_release got %b want %b", obs, 10'b0000_00_0_0_00);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1000;
        step();
        step();
        step();
        step();
        checks++;
        if (obs !== 10'b1000_11_1_0_00) begin
            errors++;
            $display("FAIL mid_hold got %b want %b", obs, 10'b1000_11_1_0_00);
        end
        rst = 1'b1;
        step();
        checks++;
        if (obs !== 10'b0000_00_0_0_00) begin
            errors++;
            $display("FAIL mid_reset got %b want %b", obs, 10'b0000_00_0_0_00);
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs !== 10'b1000_11_1_0_00) begin
            errors++;
            $display("FAIL mid_regrant got %b want %b", obs, 10'b1000_11_1_0_00);
        end
        req = 4'b0000;
        step();
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; release_i = 1'b0;
        test_reset();
        test_idle_release();
        test_basic();
        test_rotation();
        test_wrap();
        test_timeout();
        test_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
